// File: rtl/pe_packetizer_pkg.sv
// pe_packetizer_pkg: shared NoC flit constants, field positions and FSM encoding
package pe_packetizer_pkg;
  localparam int NOC_FLIT_WIDTH = 16;
  localparam int NOC_NUM_VC = 4;
  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_HEAD_TAIL = 2'b11;
  localparam int TYPE_HI = 15;
  localparam int TYPE_LO = 14;
  localparam int VC_HI = 13;
  localparam int VC_LO = 12;
  localparam int DEST_HI = 11;
  localparam int DEST_LO = 8;
  localparam int SRC_HI = 7;
  localparam int SRC_LO = 4;
  localparam int LEN_HI = 3;
  localparam int LEN_LO = 0;
  localparam int PAY_HI = 11;
  localparam int PAY_LO = 0;
  typedef enum logic [1:0] {IDLE, ALLOC, HEAD, PAYLOAD} state_t;
endpackage

// File: rtl/pe_packetizer_vc_select.sv
// vc_select: combinational lowest-index-one priority picker over on_off
module vc_select #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  on_off,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    grant = on_off & (~on_off + N'(1));
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (on_off[i]) idx = IW'(i);
  end
  assign any = |on_off;
endmodule

// File: rtl/pe_packetizer.sv
// pe_packetizer: turns PE packet requests plus a payload stream into NoC flits on one VC.
// Optional PE_PACKETIZER_STATS_EN adds saturating packet and stall counters.
module pe_packetizer
  import pe_packetizer_pkg::*;
#(
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter int NUM_VC = NOC_NUM_VC,
  parameter int MAX_PACKET_LEN = 8,
  parameter logic [3:0] CURRENT_ROUTER = 4'b0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic [3:0]            pkt_dest_i,
  input  logic [3:0]            pkt_len_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [11:0]           data_i,
  input  logic [NUM_VC-1:0]     on_off_i,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic                  valid_o,
  output logic [NUM_VC-1:0]     vc_reserved_o
`ifdef PE_PACKETIZER_STATS_EN
  ,
  output logic [15:0]           pkt_count_o,
  output logic [15:0]           stall_count_o
`endif
);
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [3:0] MAX_LEN = 4'(MAX_PACKET_LEN);
  state_t state, state_nxt;
  logic [VW-1:0] vc, pick;
  logic [NUM_VC-1:0] grant;
  logic any, vc_on, last, emit;
  logic [3:0] dest, len, cnt;
  logic [FLIT_WIDTH-1:0] flit_nxt;

  vc_select #(.N(NUM_VC), .IW(VW)) u_vc_select (
    .on_off(on_off_i),
    .grant (grant),
    .idx   (pick),
    .any   (any)
  );

  assign vc_on = on_off_i[vc];

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = pkt_valid_i ? ALLOC : IDLE;
      ALLOC:   state_nxt = any ? HEAD : ALLOC;
      HEAD:    state_nxt = !vc_on ? HEAD : (len == 4'd0) ? IDLE : PAYLOAD;
      PAYLOAD: state_nxt = (data_valid_i && vc_on && last) ? IDLE : PAYLOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pkt_ready_o = (state == IDLE) && pkt_valid_i;
    data_ready_o = (state == PAYLOAD) && vc_on;
    last = cnt == len - 4'd1;
    emit = ((state == HEAD) && vc_on) || (data_ready_o && data_valid_i);
    flit_nxt = '0;
    flit_nxt[TYPE_HI:TYPE_LO] = (state == HEAD) ? ((len == 4'd0) ? FT_HEAD_TAIL : FT_HEAD)
                                                : (last ? FT_TAIL : FT_BODY);
    flit_nxt[VC_HI:VC_LO] = 2'(vc);
    flit_nxt[PAY_HI:PAY_LO] = (state == HEAD) ? {dest, CURRENT_ROUTER, len} : data_i;
  end

  // The reserved bit drops one cycle after a packet-ending flit (TAIL or HEAD_TAIL: type MSB set) is shown
  always_ff @(posedge clk)
    if (rst) begin
      flit_o <= '0;
      valid_o <= 1'b0;
      vc_reserved_o <= '0;
      vc <= '0;
      dest <= '0;
      len <= '0;
      cnt <= '0;
    end else begin
      valid_o <= emit;
      if (emit) flit_o <= flit_nxt;
      if (pkt_ready_o) begin
        dest <= pkt_dest_i;
        len <= (pkt_len_i > MAX_LEN) ? MAX_LEN : pkt_len_i;
        cnt <= '0;
      end
      if (valid_o && flit_o[TYPE_HI]) vc_reserved_o <= '0;
      if ((state == ALLOC) && any) begin
        vc <= pick;
        vc_reserved_o <= grant;
      end
      if (data_ready_o && data_valid_i) cnt <= cnt + 4'd1;
    end

`ifdef PE_PACKETIZER_STATS_EN
  logic stall;
  assign stall = (state == ALLOC) ? !any : (state != IDLE) && !vc_on;
  always_ff @(posedge clk)
    if (rst) begin
      pkt_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      if (valid_o && flit_o[TYPE_HI] && pkt_count_o != '1) pkt_count_o <= pkt_count_o + 16'd1;
      if (stall && stall_count_o != '1) stall_count_o <= stall_count_o + 16'd1;
    end
`endif
endmodule

// File: doc/pe_packetizer.md
PE_PACKETIZER -- requirements
Module: pe_packetizer

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 16, the flit width in bits.
REQ-002 SHALL have parameter NUM_VC, default 4, the number of virtual channels on the router PE input port.
REQ-003 SHALL have parameter MAX_PACKET_LEN, default 8, the maximum number of non-head flits per packet.
REQ-004 SHALL have parameter CURRENT_ROUTER, default 4'b0100, the source address placed in head flits.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pkt_valid_i, input, 1 bit: the PE requests a new packet.
REQ-008 SHALL have port pkt_ready_o, output, 1 bit: the packet request is accepted.
REQ-009 SHALL have port pkt_dest_i, input, 4 bits: the destination router.
REQ-010 SHALL have port pkt_len_i, input, 4 bits: the count of payload flits (0 to MAX_PACKET_LEN).
REQ-011 SHALL have ports data_valid_i (input, 1 bit), data_ready_o (output, 1 bit) and data_i (input, 12 bits): the payload stream.
REQ-012 SHALL have port on_off_i, input, NUM_VC bits: the router's per-VC on/off flow control; 1 = may send.
REQ-013 SHALL have port flit_o, output, FLIT_WIDTH bits, driving the router's PE flit input.
REQ-014 SHALL have port valid_o, output, 1 bit, driving the router's PE valid input.
REQ-015 SHALL have port vc_reserved_o, output, NUM_VC bits, driving the router's PE per-VC reserved inputs.

Function
REQ-016 SHALL use this flit format: [15:14] type (00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL); [13:12] VC.
- HEAD: [11:8] destination, [7:4] CURRENT_ROUTER, [3:0] length.
- BODY and TAIL: [11:0] payload.
REQ-017 SHALL implement the FSM IDLE -> ALLOC -> HEAD -> PAYLOAD -> IDLE.
REQ-018 In IDLE with pkt_valid_i=1, SHALL pulse pkt_ready_o for 1 cycle, latch destination and length, and go to ALLOC.
- A length above MAX_PACKET_LEN SHALL be clamped to MAX_PACKET_LEN.
REQ-019 In ALLOC, SHALL select the lowest-index VC with on_off_i=1, set its vc_reserved_o bit, and go to HEAD.
- If all on_off_i bits are 0, SHALL remain in ALLOC.
REQ-020 In HEAD, when on_off_i[vc]=1, SHALL drive a registered flit with valid_o=1 for exactly one cycle.
- The flit type SHALL be HEAD_TAIL when length is 0, otherwise HEAD.
REQ-021 In PAYLOAD, SHALL assert data_ready_o only while on_off_i[vc]=1.
- On each data_valid_i && data_ready_o, SHALL emit one flit on the next cycle: BODY, with the last one TAIL.
REQ-022 SHALL have a latency of exactly 1 cycle from an accepted data beat to valid_o.
- SHALL never emit more than one flit per cycle.
REQ-023 When on_off_i[vc] drops mid-packet, SHALL hold valid_o=0 and data_ready_o=0 until it rises again, without reordering or losing flits.
- A flit already registered when on_off_i[vc] drops SHALL still be sent.
REQ-024 SHALL keep the vc_reserved_o bit set from ALLOC until the cycle after TAIL or HEAD_TAIL is emitted, then clear it.
- Exactly one bit SHALL be set while a packet is in flight.
REQ-025 SHALL set valid_o=0 in any cycle without a flit; flit_o is then don't-care but SHALL hold its last value.
REQ-026 SHALL deassert pkt_ready_o everywhere outside IDLE; a new request waits until the current packet completes.
REQ-027 A destination equal to CURRENT_ROUTER SHALL be accepted and sent normally.

Reset
REQ-028 While rst=1 at a clock edge, SHALL set: FSM to IDLE; pkt_ready_o, data_ready_o and valid_o to 0; flit_o to 0; vc_reserved_o to 0; counters to 0.
REQ-029 Reset mid-packet SHALL abort the packet; no TAIL is sent and the reserved VC is released.

Configuration
REQ-030 With PE_PACKETIZER_STATS_EN defined, SHALL add two outputs, each saturating at all-ones:
- pkt_count_o (16 bits): completed packets;
- stall_count_o (16 bits): cycles spent in ALLOC/HEAD/PAYLOAD blocked by on_off_i.
REQ-031 Without PE_PACKETIZER_STATS_EN, SHALL have neither those ports nor their logic.

Structure
REQ-032 The shared NoC package SHALL hold the flit-type constants, the flit field bit positions, FLIT_WIDTH and NUM_VC.
REQ-033 SHALL contain one sub-module, vc_select: a combinational lowest-index-one priority picker over on_off_i.

Verification
REQ-034 Reset, then dest=3, len=0, on_off=4'b0001 -> one flit 16'b11_00_0011_0100_0000 with valid_o=1; vc_reserved_o=0001, then 0000.
REQ-035 dest=12, len=2, payloads 0xABC and 0x123, on_off=4'b0001 -> HEAD 0x0C42, BODY 0x4ABC, TAIL 0x8123 on consecutive cycles.
REQ-036 on_off=4'b0000 for 5 cycles, then 4'b0100 -> no valid_o while 0000; VC 2 is then chosen and the head has [13:12]=10.
REQ-037 len=4 with on_off[vc] dropped for 3 cycles after the 2nd BODY -> exactly 5 flits, in order, none during the gap.
REQ-038 Assert rst during the 2nd BODY of a len=3 packet -> next cycle all outputs 0; the next packet starts with a HEAD.
REQ-039 len=15 -> exactly 8 payload flits, with the head length field equal to 8.
